// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider family.
package div_pkg;

   localparam int WIDTHN     = 40;
   localparam int WIDTHD     = 20;
   localparam int ITERATIONS = 40;

   localparam logic [19:0] QMAX = 20'h7FFFF;
   localparam logic [19:0] QMIN = 20'h80000;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } divState_t;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_restore_step
   import div_pkg::*;
#(
   parameter int W = WIDTHD + 1
) (
   input  logic [W-1:0] remIn,
   input  logic         nextBit,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] remOut,
   output logic         quoBit
);

   logic [W:0]   shifted;
   logic [W+1:0] trial;
   logic         unusedTrialBit;

   assign shifted = {remIn, nextBit};
   assign trial   = {1'b0, shifted} - {2'b00, divisor};

   // A kept trial result is always below the divisor, so its top magnitude bit is zero.
   assign quoBit         = ~trial[W+1];
   assign remOut         = quoBit ? trial[W-1:0] : shifted[W-1:0];
   assign unusedTrialBit = trial[W];

endmodule

// File: rtl/div_40x20_20_signed_seq.sv
// Sequential signed 40/20 divider, one restoring step per clock, Start/Busy/Done handshake.
// Define DIV_SATURATE_EN to clamp an overflowing quotient instead of wrapping it.
module div_40x20_20_signed_seq
   import div_pkg::*;
#(
   parameter int lpm_widthn         = WIDTHN,
   parameter int lpm_widthd         = WIDTHD,
   parameter     lpm_representation = "SIGNED"
) (
   input  logic                  Clock,
   input  logic                  Sclr,
   input  logic                  Start,
   input  logic [lpm_widthn-1:0] Numer,
   input  logic [lpm_widthd-1:0] Denom,
   output logic [lpm_widthd-1:0] Quotient,
   output logic [lpm_widthd-1:0] Remain,
   output logic                  Busy,
   output logic                  Done,
   output logic                  DivByZero,
   output logic                  Overflow
);

   localparam int CW = $clog2(ITERATIONS);
   localparam bit SignedRep = (lpm_representation == "SIGNED");
   localparam logic [lpm_widthn-1:0] MagPosLim = lpm_widthn'(QMAX);
   localparam logic [lpm_widthn-1:0] MagNegLim = lpm_widthn'(QMAX) + lpm_widthn'(1);

   divState_t             state;
   logic [lpm_widthn:0]   numMag;
   logic [lpm_widthd:0]   denMag;
   logic [lpm_widthd:0]   remReg;
   logic [lpm_widthn-1:0] quoMag;
   logic [CW-1:0]         count;
   logic                  sq;
   logic                  sr;
   logic                  dz;

   logic                  numNeg;
   logic                  denNeg;
   logic                  denZero;
   logic [lpm_widthn:0]   numAbs;
   logic [lpm_widthd:0]   denAbs;
   logic [lpm_widthd:0]   stepRem;
   logic                  stepBit;

   logic [lpm_widthd-1:0] qLow;
   logic [lpm_widthd-1:0] qOut;
   logic [lpm_widthd-1:0] remSigned;
   logic [lpm_widthd-1:0] dzQuo;
   logic [lpm_widthd-1:0] dzRem;
   logic                  ovf;

   // Magnitudes carry one extra bit so the most negative operands stay exact.
   assign numNeg  = SignedRep && Numer[lpm_widthn-1];
   assign denNeg  = SignedRep && Denom[lpm_widthd-1];
   assign denZero = (Denom == '0);
   assign numAbs  = numNeg ? -{Numer[lpm_widthn-1], Numer} : {1'b0, Numer};
   assign denAbs  = denNeg ? -{Denom[lpm_widthd-1], Denom} : {1'b0, Denom};

   div_restore_step #(
      .W(lpm_widthd + 1)
   ) u_step (
      .remIn  (remReg),
      .nextBit(numMag[count]),
      .divisor(denMag),
      .remOut (stepRem),
      .quoBit (stepBit)
   );

   // Low bits of a negated magnitude equal the negation of its low bits.
   assign qLow      = sq ? -quoMag[lpm_widthd-1:0] : quoMag[lpm_widthd-1:0];
   assign ovf       = sq ? (quoMag > MagNegLim) : (quoMag > MagPosLim);
   assign remSigned = sr ? -remReg[lpm_widthd-1:0] : remReg[lpm_widthd-1:0];
   assign dzQuo     = sr ? QMIN : QMAX;
   assign dzRem     = sr ? -numMag[lpm_widthd-1:0] : numMag[lpm_widthd-1:0];

   // Quotient presented on overflow: clamp to the signed range or keep the wrapped low bits.
   always_comb begin
      qOut = qLow;
`ifdef DIV_SATURATE_EN
      if (ovf) begin
         qOut = sq ? QMIN : QMAX;
      end
`endif
   end

   // Control FSM, iteration datapath and registered result outputs.
   always_ff @(posedge Clock) begin
      if (Sclr) begin
         state     <= IDLE;
         numMag    <= '0;
         denMag    <= '0;
         remReg    <= '0;
         quoMag    <= '0;
         count     <= '0;
         sq        <= 1'b0;
         sr        <= 1'b0;
         dz        <= 1'b0;
         Quotient  <= '0;
         Remain    <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         Overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               Done <= 1'b0;
               if (Start) begin
                  numMag <= numAbs;
                  denMag <= denAbs;
                  sq     <= numNeg ^ denNeg;
                  sr     <= numNeg;
                  dz     <= denZero;
                  remReg <= '0;
                  quoMag <= '0;
                  count  <= CW'(ITERATIONS - 1);
                  Busy   <= 1'b1;
                  state  <= denZero ? FIX : CALC;
               end
            end
            CALC: begin
               remReg <= stepRem;
               quoMag <= {quoMag[lpm_widthn-2:0], stepBit};
               if (count == '0) begin
                  state <= FIX;
               end else begin
                  count <= count - 1'b1;
               end
            end
            FIX: begin
               Busy  <= 1'b0;
               Done  <= 1'b1;
               state <= IDLE;
               if (dz) begin
                  Quotient  <= dzQuo;
                  Remain    <= dzRem;
                  DivByZero <= 1'b1;
                  Overflow  <= 1'b0;
               end else begin
                  Quotient  <= qOut;
                  Remain    <= remSigned;
                  DivByZero <= 1'b0;
                  Overflow  <= ovf;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_40x20_20_signed_seq.sv
// Self-checking bench for div_40x20_20_signed_seq: arithmetic reference model plus directed vectors.
// Honours DIV_SATURATE_EN the same way as the design.
module tb_div_40x20_20_signed_seq;

`ifdef DIV_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        Clock = 1'b0;
   logic        Sclr;
   logic        Start;
   logic [39:0] Numer;
   logic [19:0] Denom;
   logic [19:0] Quotient;
   logic [19:0] Remain;
   logic        Busy;
   logic        Done;
   logic        DivByZero;
   logic        Overflow;

   int compared   = 0;
   int mismatched = 0;

   div_40x20_20_signed_seq dut (
      .Clock    (Clock),
      .Sclr     (Sclr),
      .Start    (Start),
      .Numer    (Numer),
      .Denom    (Denom),
      .Quotient (Quotient),
      .Remain   (Remain),
      .Busy     (Busy),
      .Done     (Done),
      .DivByZero(DivByZero),
      .Overflow (Overflow)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [19:0] q;
      logic [19:0] r;
      logic        dz;
      logic        ov;
   } res_t;

   typedef struct {
      logic [39:0] n;
      logic [19:0] d;
      logic [19:0] qWrap;
      logic [19:0] qSat;
      logic [19:0] r;
      logic        dz;
      logic        ov;
      int          lat;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs[NV];

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Truncating signed division straight from the arithmetic definition.
   function automatic res_t modelDiv(input logic [39:0] n, input logic [19:0] d);
      res_t   res;
      longint ln;
      longint ld;
      longint lq;
      longint lr;
      ln = longint'($signed(n));
      ld = longint'($signed(d));
      if (ld == 0) begin
         res.q  = (ln < 0) ? 20'h80000 : 20'h7FFFF;
         res.r  = n[19:0];
         res.dz = 1'b1;
         res.ov = 1'b0;
      end else begin
         lq     = ln / ld;
         lr     = ln % ld;
         res.dz = 1'b0;
         res.ov = (lq > 524287) || (lq < -524288);
         res.q  = lq[19:0];
         if (SAT && res.ov) begin
            res.q = (lq < 0) ? 20'h80000 : 20'h7FFFF;
         end
         res.r = lr[19:0];
      end
      return res;
   endfunction

   // Handshake-level model: an accepted request resolves a fixed number of edges later.
   int   cyc     = 0;
   int   fixEdge = -1;
   int   doneAt  = -1;
   bit   active  = 1'b0;
   res_t cur;
   res_t pend;

   initial begin
      cur = '{20'h0, 20'h0, 1'b0, 1'b0};
      pend = cur;
      forever begin
         @(posedge Clock);
         cyc++;
         if (Sclr) begin
            active = 1'b0;
            doneAt = -1;
            cur    = '{20'h0, 20'h0, 1'b0, 1'b0};
         end else if (!active && Start) begin
            pend    = modelDiv(Numer, Denom);
            active  = 1'b1;
            fixEdge = cyc + ((Denom == 20'h0) ? 1 : 41);
         end else if (active && cyc == fixEdge) begin
            cur    = pend;
            active = 1'b0;
            doneAt = cyc;
         end
      end
   end

   // Every cycle the registered outputs must match the model.
   initial begin
      @(posedge Clock);
      forever begin
         @(negedge Clock);
         checkValue("cyc.busy", Busy, active);
         checkValue("cyc.done", Done, (doneAt == cyc));
         checkValue("cyc.quotient", Quotient, cur.q);
         checkValue("cyc.remain", Remain, cur.r);
         checkValue("cyc.divbyzero", DivByZero, cur.dz);
         checkValue("cyc.overflow", Overflow, cur.ov);
      end
   end

   task automatic applyStimulus(input logic [39:0] n, input logic [19:0] d);
      Numer = n;
      Denom = d;
      Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [19:0] q, input logic [19:0] r,
                              input logic dz, input logic ov, input int lat);
      int seen    = -1;
      int busyCnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge Clock);
         if (Done === 1'b1) begin
            seen = i;
            break;
         end
         if (Busy === 1'b1) busyCnt++;
      end
      checkValue({name, ".latency"}, seen, lat);
      checkValue({name, ".busyCycles"}, busyCnt, lat);
      checkValue({name, ".quotient"}, Quotient, q);
      checkValue({name, ".remain"}, Remain, r);
      checkValue({name, ".divbyzero"}, DivByZero, dz);
      checkValue({name, ".overflow"}, Overflow, ov);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int seen;
      int doneCount;

      vecs[0]  = '{40'd100,          20'd7,      20'h0000E, 20'h0000E, 20'h00002, 1'b0, 1'b0, 41};
      vecs[1]  = '{40'hFFFFFFFF9C,   20'd7,      20'hFFFF2, 20'hFFFF2, 20'hFFFFE, 1'b0, 1'b0, 41};
      vecs[2]  = '{40'd100,          20'hFFFF9,  20'hFFFF2, 20'hFFFF2, 20'h00002, 1'b0, 1'b0, 41};
      vecs[3]  = '{40'hFFFFE80000,   20'd3,      20'h80000, 20'h80000, 20'h00000, 1'b0, 1'b0, 41};
      vecs[4]  = '{40'd5,            20'd0,      20'h7FFFF, 20'h7FFFF, 20'h00005, 1'b1, 1'b0, 1};
      vecs[5]  = '{40'hFFFFFFFFFB,   20'd0,      20'h80000, 20'h80000, 20'hFFFFB, 1'b1, 1'b0, 1};
      vecs[6]  = '{40'h0040000000,   20'd1,      20'h00000, 20'h7FFFF, 20'h00000, 1'b0, 1'b1, 41};
      vecs[7]  = '{40'h8000000000,   20'hFFFFF,  20'h00000, 20'h7FFFF, 20'h00000, 1'b0, 1'b1, 41};
      vecs[8]  = '{40'h000007FFFF,   20'd1,      20'h7FFFF, 20'h7FFFF, 20'h00000, 1'b0, 1'b0, 41};
      vecs[9]  = '{40'h0000080000,   20'd1,      20'h80000, 20'h7FFFF, 20'h00000, 1'b0, 1'b1, 41};
      vecs[10] = '{40'hFFFFFFFFF9,   20'd2,      20'hFFFFD, 20'hFFFFD, 20'hFFFFF, 1'b0, 1'b0, 41};
      vecs[11] = '{40'h00000F4240,   20'h80000,  20'hFFFFF, 20'hFFFFF, 20'h74240, 1'b0, 1'b0, 41};

      Sclr  = 1'b1;
      Start = 1'b0;
      Numer = 40'h0;
      Denom = 20'h0;
      repeat (3) @(posedge Clock);
      #1;
      Sclr = 1'b0;

      @(negedge Clock);
      checkValue("reset.busy", Busy, 1'b0);
      checkValue("reset.done", Done, 1'b0);
      checkValue("reset.quotient", Quotient, 20'h0);
      checkValue("reset.remain", Remain, 20'h0);
      checkValue("reset.divbyzero", DivByZero, 1'b0);
      checkValue("reset.overflow", Overflow, 1'b0);

      for (int k = 0; k < NV; k++) begin
         @(negedge Clock);
         applyStimulus(vecs[k].n, vecs[k].d);
         checkOutput($sformatf("vec%0d", k), SAT ? vecs[k].qSat : vecs[k].qWrap,
                     vecs[k].r, vecs[k].dz, vecs[k].ov, vecs[k].lat);
      end

      // Abort a division mid-iteration; outputs clear and no Done follows.
      @(negedge Clock);
      applyStimulus(40'd100, 20'd7);
      repeat (20) @(negedge Clock);
      Sclr = 1'b1;
      @(negedge Clock);
      Sclr = 1'b0;
      checkValue("sclr.busy", Busy, 1'b0);
      checkValue("sclr.done", Done, 1'b0);
      checkValue("sclr.quotient", Quotient, 20'h0);
      checkValue("sclr.remain", Remain, 20'h0);
      doneCount = 0;
      repeat (50) begin
         @(negedge Clock);
         if (Done === 1'b1) doneCount++;
      end
      checkValue("sclr.noDone", doneCount, 0);

      // Start pulses while busy must not disturb the running division.
      @(negedge Clock);
      applyStimulus(40'd1000, 20'd10);
      seen = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge Clock);
         if (Done === 1'b1) begin
            seen = i;
            break;
         end
         if (i == 5) begin
            Numer = 40'd77;
            Denom = 20'd0;
            Start = 1'b1;
         end
         if (i == 8) Start = 1'b0;
      end
      checkValue("ignore.latency", seen, 41);
      checkValue("ignore.quotient", Quotient, 20'h00064);
      checkValue("ignore.remain", Remain, 20'h00000);
      checkValue("ignore.divbyzero", DivByZero, 1'b0);

      // Back-to-back: the second Start is raised during the Done cycle.
      @(negedge Clock);
      applyStimulus(40'hFFFFFFFF9C, 20'd7);
      checkOutput("b2b.first", 20'hFFFF2, 20'hFFFFE, 1'b0, 1'b0, 41);
      applyStimulus(40'd100, 20'hFFFF9);
      checkOutput("b2b.second", 20'hFFFF2, 20'h00002, 1'b0, 1'b0, 41);

      repeat (3) @(negedge Clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
